load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator side of the core's data-memory bus: turns core load/store requests (RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW) into word-aligned memory transactions with byte enables.
- Sits between the execute stage and data memory. Stalls the core until read data returns after a fixed memory latency.
- Performs write-data lane replication, read-data lane extraction with sign/zero extension, and misalignment detection.

Parameters:
- MEM_LATENCY, 1, cycles from mem_req_o accept to valid mem_rd_i; legal range 1..15.

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous active-low reset
- lsu_req_i  in  1  core requests a memory access; held stable while lsu_stall_o=1
- lsu_we_i  in  1  1=store, 0=load
- lsu_size_i  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; others illegal
- lsu_addr_i  in  32  byte address
- lsu_data_i  in  32  store data (low bits used for B/H)
- lsu_data_o  out  32  extended load result
- lsu_stall_o  out  1  core must hold the pipeline
- lsu_misalign_o  out  1  one-cycle pulse: misaligned or illegal access rejected
- mem_req_o  out  1  memory request strobe
- mem_we_o  out  1  memory write enable
- mem_be_o  out  4  byte enables, bit n = byte lane n
- mem_addr_o  out  32  {lsu_addr_i[31:2], 2'b00}
- mem_wd_o  out  32  lane-replicated write data
- mem_rd_i  in  32  memory read word, valid MEM_LATENCY cycles after request

Behaviour:
- Reset (rst_i=0, asynchronous):
  - FSM enters IDLE; latency counter = 0.
  - lsu_data_o = 0; lsu_stall_o = 0; lsu_misalign_o = 0.
  - mem_req_o = 0; mem_we_o = 0; mem_be_o = 0.
  - Reset mid-transaction aborts it; no further memory strobes.
- FSM states: IDLE, WAIT, DONE.
- Legality check:
  - Misaligned means: H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - Illegal means: lsu_size_i not in {000,001,010,100,101}, or a store with size 100/101.
- IDLE with lsu_req_i=1 and the access misaligned or illegal:
  - mem_req_o stays 0.
  - lsu_misalign_o=1 for that cycle; lsu_stall_o=0.
  - Stay IDLE.
- IDLE with lsu_req_i=1 and the access legal:
  - Combinationally: mem_req_o=1, mem_we_o=lsu_we_i, mem_be_o, mem_addr_o, mem_wd_o all valid; lsu_stall_o=1.
  - Latch offset, size and we into registers.
  - Load counter with MEM_LATENCY-1. Go to WAIT if MEM_LATENCY>1, else DONE.
- WAIT:
  - mem_req_o=0; lsu_stall_o=1.
  - Counter decrements each cycle; at 1 go to DONE.
- DONE:
  - lsu_stall_o=0.
  - Loads: lsu_data_o is extracted combinationally from mem_rd_i and also registered, so it holds until the next load completes.
  - Stores: lsu_data_o is unchanged.
  - Next state is IDLE. A new lsu_req_i in DONE is not accepted; it is accepted in the following IDLE cycle.
- Total stall: MEM_LATENCY cycles per legal access. The core sees stall=0 in the DONE cycle and advances.
- Byte enables:
  - B: 4'b0001 << addr[1:0].
  - H: 4'b0011 << addr[1:0] (addr[1:0] is 0 or 2).
  - W: 4'b1111.
  - Loads drive the same enables (informative).
- Write data:
  - B: {4{data[7:0]}}.
  - H: {2{data[15:0]}}.
  - W: data unchanged.
- Read extraction: select byte or half by the latched offset.
  - B/H: sign-extend from bit 7/15.
  - BU/HU: zero-extend.
  - W: pass through.
- lsu_req_i=0 in IDLE: all mem outputs 0, stall 0.
- Address wrap: none; mem_addr_o is pure truncation of low bits.

Test Plan:
- Reset released with lsu_req_i=1, SW addr 0x88000004, data 0xDEADBEEF, MEM_LATENCY=1:
  - Required: mem_req_o=1, be=1111, addr=0x88000004, wd=0xDEADBEEF, stall=1 for 1 cycle.
  - Next cycle stall=0.
- LB from addr 0x88000007 with mem_rd_i=0x80123456:
  - Required: be=1000, lsu_data_o=0xFFFFFF80.
  - Repeat as LBU: lsu_data_o=0x00000080.
- SH data 0x0000ABCD to addr 0x88000002:
  - Required: be=1100, wd=0xABCDABCD.
  - LHU same address with mem_rd_i=0xABCD1234 -> 0x0000ABCD; LH -> 0xFFFFABCD.
- LW at 0x88000001, then SH at 0x88000003:
  - Required: lsu_misalign_o pulses 1 cycle each, mem_req_o never 1, stall 0.
  - Store with size 100 -> lsu_misalign_o pulse.
- MEM_LATENCY=3, back-to-back LW requests:
  - Required: each access stalls exactly 3 cycles with mem_req_o high only in the first.
  - Second request issues one cycle after DONE.
- Assert rst_i=0 while in WAIT (MEM_LATENCY=4):
  - Required: stall, mem_req_o, lsu_data_o drop to 0 immediately; FSM resumes in IDLE after release.

Source files
------------

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - core-side and memory-side signal bundle of the load/store unit
interface load_store_unit_if;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [2:0]  lsu_size_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_data_i;
  logic [31:0] lsu_data_o;
  logic        lsu_stall_o;
  logic        lsu_misalign_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;

  // master: the load/store unit itself
  modport master (
    input  lsu_req_i, lsu_we_i, lsu_size_i, lsu_addr_i, lsu_data_i, mem_rd_i,
    output lsu_data_o, lsu_stall_o, lsu_misalign_o,
           mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
  );

  // slave: the surrounding core and data memory
  modport slave (
    output lsu_req_i, lsu_we_i, lsu_size_i, lsu_addr_i, lsu_data_i, mem_rd_i,
    input  lsu_data_o, lsu_stall_o, lsu_misalign_o,
           mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RISC-V load/store unit driving a fixed-latency word memory
module load_store_unit #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  load_store_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  off_q;
  logic [2:0]  size_q;
  logic        we_q;
  logic [31:0] data_q;

  logic        size_ok, illegal, misaligned, accept;
  logic [3:0]  be;
  logic [31:0] wd;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;

  logic        stall, misalign, mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wd;

  assign size_ok = (bus.lsu_size_i == 3'b000) || (bus.lsu_size_i == 3'b001) ||
                   (bus.lsu_size_i == 3'b010) || (bus.lsu_size_i == 3'b100) ||
                   (bus.lsu_size_i == 3'b101);
  // unsigned sizes only make sense for loads
  assign illegal    = !size_ok || (bus.lsu_we_i && bus.lsu_size_i[2]);
  assign misaligned = ((bus.lsu_size_i[1:0] == 2'b01) && bus.lsu_addr_i[0]) ||
                      ((bus.lsu_size_i == 3'b010) && (bus.lsu_addr_i[1:0] != 2'b00));

  always_comb begin
    be = 4'b1111;
    wd = bus.lsu_data_i;
    case (bus.lsu_size_i[1:0])
      2'b00: begin
        be = 4'b0001 << bus.lsu_addr_i[1:0];
        wd = {4{bus.lsu_data_i[7:0]}};
      end
      2'b01: begin
        be = 4'b0011 << bus.lsu_addr_i[1:0];
        wd = {2{bus.lsu_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_byte = bus.mem_rd_i[7:0];
    case (off_q)
      2'd1:    rd_byte = bus.mem_rd_i[15:8];
      2'd2:    rd_byte = bus.mem_rd_i[23:16];
      2'd3:    rd_byte = bus.mem_rd_i[31:24];
      default: ;
    endcase
    rd_half = off_q[1] ? bus.mem_rd_i[31:16] : bus.mem_rd_i[15:0];
    case (size_q)
      3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  rd_ext = {24'd0, rd_byte};
      3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
      3'b101:  rd_ext = {16'd0, rd_half};
      default: rd_ext = bus.mem_rd_i;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    stall    = 1'b0;
    misalign = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_be   = 4'b0000;
    mem_addr = 32'd0;
    mem_wd   = 32'd0;
    case (state_q)
      IDLE: begin
        if (bus.lsu_req_i) begin
          if (illegal || misaligned) begin
            misalign = 1'b1;
          end else begin
            accept   = 1'b1;
            stall    = 1'b1;
            mem_req  = 1'b1;
            mem_we   = bus.lsu_we_i;
            mem_be   = be;
            mem_addr = {bus.lsu_addr_i[31:2], 2'b00};
            mem_wd   = wd;
            cnt_d    = 4'(MEM_LATENCY - 1);
            state_d  = (MEM_LATENCY > 1) ? WAIT : DONE;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // while reset is held the state is IDLE, but a pending request must not strobe memory
    if (!rst_i) begin
      accept   = 1'b0;
      stall    = 1'b0;
      misalign = 1'b0;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      mem_be   = 4'b0000;
      mem_addr = 32'd0;
      mem_wd   = 32'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      off_q   <= 2'd0;
      size_q  <= 3'd0;
      we_q    <= 1'b0;
      data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        off_q  <= bus.lsu_addr_i[1:0];
        size_q <= bus.lsu_size_i;
        we_q   <= bus.lsu_we_i;
      end
      if ((state_q == DONE) && !we_q) begin
        data_q <= rd_ext;
      end
    end
  end

  // the load result is visible combinationally in DONE and held afterwards
  assign bus.lsu_data_o     = ((state_q == DONE) && !we_q) ? rd_ext : data_q;
  assign bus.lsu_stall_o    = stall;
  assign bus.lsu_misalign_o = misalign;
  assign bus.mem_req_o      = mem_req;
  assign bus.mem_we_o       = mem_we;
  assign bus.mem_be_o       = mem_be;
  assign bus.mem_addr_o     = mem_addr;
  assign bus.mem_wd_o       = mem_wd;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit at latencies 1, 3 and 4
module tb_load_store_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  req, we;
  logic [2:0]  size [3];
  logic [31:0] addr [3];
  logic [31:0] wdat [3];
  logic [31:0] rd   [3];

  logic [2:0]  o_stall, o_mis, o_req, o_we;
  logic [3:0]  o_be   [3];
  logic [31:0] o_data [3];
  logic [31:0] o_addr [3];
  logic [31:0] o_wd   [3];

  int checks = 0;
  int errors = 0;
  logic [31:0] last_load [3];

  genvar g;
  for (g = 0; g < 3; g++) begin : gi
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    load_store_unit_if bus ();
    load_store_unit #(.MEM_LATENCY(L)) dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus.master)
    );
    assign bus.lsu_req_i  = req[g];
    assign bus.lsu_we_i   = we[g];
    assign bus.lsu_size_i = size[g];
    assign bus.lsu_addr_i = addr[g];
    assign bus.lsu_data_i = wdat[g];
    assign bus.mem_rd_i   = rd[g];
    assign o_stall[g] = bus.lsu_stall_o;
    assign o_mis[g]   = bus.lsu_misalign_o;
    assign o_req[g]   = bus.mem_req_o;
    assign o_we[g]    = bus.mem_we_o;
    assign o_be[g]    = bus.mem_be_o;
    assign o_data[g]  = bus.lsu_data_o;
    assign o_addr[g]  = bus.mem_addr_o;
    assign o_wd[g]    = bus.mem_wd_o;
  end

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge with unit k idle; returns just after a rising edge with k idle.
  task automatic do_access(input int k, input bit w, input bit [2:0] sz,
                           input bit [31:0] a, input bit [31:0] d, input bit [31:0] r);
    int          off;
    int          lat;
    int          b;
    int          h;
    bit          legal;
    bit [3:0]    exp_be;
    bit [31:0]   exp_wd;
    bit [31:0]   res;
    off = int'(a[1:0]);
    lat = lat_of(k);
    req[k] = 1'b1; we[k] = w; size[k] = sz; addr[k] = a; wdat[k] = d; rd[k] = r;

    legal = (sz inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) && !(w && sz[2]) &&
            !((sz == 3'b001 || sz == 3'b101) && (off % 2 == 1)) && !(sz == 3'b010 && off != 0);
    if (sz == 3'b000 || sz == 3'b100) begin
      exp_be = 4'(1 << off);
      exp_wd = {24'd0, d[7:0]} * 32'h0101_0101;
    end else if (sz == 3'b001 || sz == 3'b101) begin
      exp_be = 4'(3 << off);
      exp_wd = {16'd0, d[15:0]} * 32'h0001_0001;
    end else begin
      exp_be = 4'hF;
      exp_wd = d;
    end
    b = int'((r >> (8 * off)) & 32'hFF);
    h = int'((r >> (8 * off)) & 32'hFFFF);
    case (sz)
      3'b000:  res = 32'((b >= 128) ? b - 256 : b);
      3'b100:  res = 32'(b);
      3'b001:  res = 32'((h >= 32768) ? h - 65536 : h);
      3'b101:  res = 32'(h);
      default: res = r;
    endcase

    @(negedge clk);
    if (!legal) begin
      chk("rej_misalign", {31'd0, o_mis[k]}, 32'd1);
      chk("rej_mem_req", {31'd0, o_req[k]}, 32'd0);
      chk("rej_stall", {31'd0, o_stall[k]}, 32'd0);
      chk("rej_data_held", o_data[k], last_load[k]);
      @(posedge clk); #1;
      req[k] = 1'b0;
      #1;
      chk("rej_pulse_end", {31'd0, o_mis[k]}, 32'd0);
      @(posedge clk); #1;
      return;
    end

    chk("issue_mem_req", {31'd0, o_req[k]}, 32'd1);
    chk("issue_we", {31'd0, o_we[k]}, {31'd0, w});
    chk("issue_be", {28'd0, o_be[k]}, {28'd0, exp_be});
    chk("issue_addr", o_addr[k], a & 32'hFFFF_FFFC);
    chk("issue_stall", {31'd0, o_stall[k]}, 32'd1);
    chk("issue_misalign", {31'd0, o_mis[k]}, 32'd0);
    if (w) chk("issue_wd", o_wd[k], exp_wd);

    for (int c = 1; c < lat; c++) begin
      @(negedge clk);
      chk("wait_stall", {31'd0, o_stall[k]}, 32'd1);
      chk("wait_mem_req", {31'd0, o_req[k]}, 32'd0);
    end

    // request is still held here; it must not be taken until the next idle cycle
    @(negedge clk);
    chk("done_stall", {31'd0, o_stall[k]}, 32'd0);
    chk("done_mem_req", {31'd0, o_req[k]}, 32'd0);
    if (!w) chk("done_load_data", o_data[k], res);
    else    chk("done_store_data", o_data[k], last_load[k]);

    @(posedge clk); #1;
    req[k] = 1'b0;
    if (!w) last_load[k] = res;
    #1;
    chk("idle_data_held", o_data[k], last_load[k]);
    chk("idle_mem_req", {31'd0, o_req[k]}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; size[i] = 3'd0;
      addr[i] = 32'd0; wdat[i] = 32'd0; rd[i] = 32'd0; last_load[i] = 32'd0;
    end
    // unit 0 already requests a store while reset is held
    req[0] = 1'b1; we[0] = 1'b1; size[0] = 3'b010; addr[0] = 32'h8800_0004; wdat[0] = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_stall", {31'd0, o_stall[k]}, 32'd0);
      chk("rst_mem_req", {31'd0, o_req[k]}, 32'd0);
      chk("rst_we", {31'd0, o_we[k]}, 32'd0);
      chk("rst_be", {28'd0, o_be[k]}, 32'd0);
      chk("rst_data", o_data[k], 32'd0);
      chk("rst_misalign", {31'd0, o_mis[k]}, 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_access(0, 1'b1, 3'b010, 32'h8800_0004, 32'hDEAD_BEEF, 32'd0);
    do_access(0, 1'b0, 3'b000, 32'h8800_0007, 32'd0, 32'h8012_3456);
    do_access(0, 1'b0, 3'b100, 32'h8800_0007, 32'd0, 32'h8012_3456);
    do_access(0, 1'b1, 3'b001, 32'h8800_0002, 32'h0000_ABCD, 32'd0);
    do_access(0, 1'b0, 3'b101, 32'h8800_0002, 32'd0, 32'hABCD_1234);
    do_access(0, 1'b0, 3'b001, 32'h8800_0002, 32'd0, 32'hABCD_1234);
    do_access(0, 1'b0, 3'b010, 32'h8800_0001, 32'd0, 32'h1111_1111);
    do_access(0, 1'b1, 3'b001, 32'h8800_0003, 32'h1234_5678, 32'd0);
    do_access(0, 1'b1, 3'b100, 32'h8800_0000, 32'h1234_5678, 32'd0);
    do_access(0, 1'b0, 3'b011, 32'h8800_0000, 32'd0, 32'h2222_2222);

    do_access(1, 1'b0, 3'b010, 32'h8800_0010, 32'd0, 32'hCAFE_F00D);
    do_access(1, 1'b0, 3'b010, 32'h8800_0014, 32'd0, 32'h0BAD_C0DE);
    do_access(1, 1'b1, 3'b000, 32'h8800_0013, 32'h0000_00A5, 32'd0);

    // reset asserted while unit 2 is waiting on memory
    do_access(2, 1'b0, 3'b010, 32'h8800_0020, 32'd0, 32'h1234_5678);
    req[2] = 1'b1; we[2] = 1'b0; size[2] = 3'b010; addr[2] = 32'h8800_0024; rd[2] = 32'h5555_AAAA;
    @(negedge clk);
    chk("mid_issue", {31'd0, o_req[2]}, 32'd1);
    @(negedge clk);
    chk("mid_wait_stall", {31'd0, o_stall[2]}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", {31'd0, o_stall[2]}, 32'd0);
    chk("mid_rst_mem_req", {31'd0, o_req[2]}, 32'd0);
    chk("mid_rst_data", o_data[2], 32'd0);
    for (int i = 0; i < 3; i++) last_load[i] = 32'd0;
    @(negedge clk);
    chk("mid_rst_held_req", {31'd0, o_req[2]}, 32'd0);
    req[2] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_stall", {31'd0, o_stall[2]}, 32'd0);
    chk("post_rst_data", o_data[2], 32'd0);
    do_access(2, 1'b0, 3'b000, 32'h8800_0031, 32'd0, 32'h0000_F100);

    for (int n = 0; n < 80; n++) begin
      do_access($urandom_range(0, 2), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                $urandom, $urandom, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
